// File: rtl/pb_pkg.sv
// Shared push-button definitions: event codes and gesture FSM state encoding.
package pb_pkg;

  localparam int unsigned EVT_W = 2;

  localparam logic [EVT_W-1:0] EVT_NONE   = 2'b00;
  localparam logic [EVT_W-1:0] EVT_SHORT  = 2'b01;
  localparam logic [EVT_W-1:0] EVT_LONG   = 2'b10;
  localparam logic [EVT_W-1:0] EVT_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_GAP       = 3'd3,
    ST_PRESS2    = 3'd4
  } pb_state_e;

endpackage

// File: rtl/pb_evt_slot.sv
// One-entry valid/ready event holding register; pulses ovf when a new event finds it full.
module pb_evt_slot
  import pb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             new_valid,
  input  logic [EVT_W-1:0] new_code,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_code,
  output logic             evt_ovf
);

  logic             valid_q, valid_d;
  logic [EVT_W-1:0] code_q, code_d;
  logic             ovf_q, ovf_d;

  // Acceptance frees the slot in the same cycle, so a new event can load back-to-back.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    if (valid_q && evt_ready) begin
      valid_d = 1'b0;
      code_d  = EVT_NONE;
    end
    if (new_valid) begin
      if (!valid_q || evt_ready) begin
        valid_d = 1'b1;
        code_d  = new_code;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      code_q  <= EVT_NONE;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_code  = code_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: rtl/pb_gesture.sv
// Classifies debounced press/release pulses into SHORT, LONG or DOUBLE gestures.
module pb_gesture
  import pb_pkg::*;
#(
  parameter int unsigned      CNT_W      = 24,
  parameter logic [CNT_W-1:0] LONG_TICKS = CNT_W'(5_000_000),
  parameter logic [CNT_W-1:0] GAP_TICKS  = CNT_W'(2_500_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prss,
  input  logic             rls,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_code,
  output logic             evt_ovf,
  output logic             held
);

  pb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             dbl_q, dbl_d;
  logic             gen_valid;
  logic [EVT_W-1:0] gen_code;

  // DOUBLE is staged one cycle through dbl_q so it appears one edge after the release.
  always_comb begin
    state_d   = state_q;
    dbl_d     = 1'b0;
    gen_valid = dbl_q;
    gen_code  = dbl_q ? EVT_DOUBLE : EVT_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (prss && !rls) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (rls) begin
          state_d = ST_GAP;
        end else if (cnt_q == LONG_TICKS - CNT_W'(1)) begin
          state_d   = ST_LONG_HELD;
          gen_valid = 1'b1;
          gen_code  = EVT_LONG;
        end
      end
      ST_LONG_HELD: begin
        if (rls) state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (prss && !rls) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == GAP_TICKS - CNT_W'(1)) begin
          state_d   = ST_IDLE;
          gen_valid = 1'b1;
          gen_code  = EVT_SHORT;
        end
      end
      ST_PRESS2: begin
        if (rls) begin
          state_d = ST_IDLE;
          dbl_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    held_d = (state_d == ST_PRESS1) || (state_d == ST_LONG_HELD) || (state_d == ST_PRESS2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      dbl_q   <= dbl_d;
    end
  end

  assign held = held_q;

  pb_evt_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .new_valid (gen_valid),
    .new_code  (gen_code),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ovf   (evt_ovf)
  );

endmodule

// File: doc/pb_gesture.md
# pb_gesture

Button-gesture classifier that consumes the single-cycle press/release pulses produced by the push-button debounce/edge stage. It times hold duration and inter-press gap to classify each gesture as SHORT, LONG or DOUBLE. Each result is delivered as a registered valid/ready event to the serial command logic.

## Interface
- LONG_TICKS, 24'd5_000_000: clk cycles in first press that qualify a LONG press.
- GAP_TICKS, 24'd2_500_000: max clk cycles after a short release during which a second press makes a DOUBLE.
- CNT_W, 24: counter width; must hold max(LONG_TICKS, GAP_TICKS).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- prss  in  1  one-cycle press pulse from the debounce stage.
- rls  in  1  one-cycle release pulse from the debounce stage.
- evt_ready  in  1  consumer accepts the event when high with evt_valid.
- evt_valid  out  1  event pending.
- evt_code  out  2  2'b01 SHORT, 2'b10 LONG, 2'b11 DOUBLE; 2'b00 whenever evt_valid=0.
- evt_ovf  out  1  one-cycle pulse: new event dropped because slot full.
- held  out  1  high while button is considered down.

## Operation
- States: IDLE, PRESS1, LONG_HELD, GAP, PRESS2. cnt (CNT_W bits) clears on every state change and increments each cycle otherwise, saturating.
- IDLE: prss -> PRESS1. rls ignored.
- PRESS1: rls -> GAP. Otherwise, cnt==LONG_TICKS-1 -> generate LONG, go to LONG_HELD. rls wins over a simultaneous terminal count (classified short).
- LONG_HELD: rls -> IDLE. No further events.
- GAP: prss -> PRESS2. Otherwise, cnt==GAP_TICKS-1 -> generate SHORT, go to IDLE. prss wins over a simultaneous timeout.
- PRESS2: rls -> generate DOUBLE, go to IDLE. No long timing on the second press.
- prss in PRESS1/LONG_HELD/PRESS2 and rls in IDLE/GAP are ignored. If prss and rls are both high, rls is used and prss is ignored.
- held=1 in PRESS1, LONG_HELD and PRESS2.
- Event slot: a generated event loads into the slot if evt_valid=0, or if evt_valid=1 and evt_ready=1 in the same cycle (back-to-back). Otherwise the new event is dropped and evt_ovf pulses. evt_valid/evt_code stay stable until accepted. Acceptance with no new event clears evt_valid.

## Timing
- Reset: state=IDLE, cnt=0, evt_valid=0, evt_code=2'b00, evt_ovf=0, held=0. Asserting reset mid-gesture discards the gesture and any pending event.
- prss sampled at edge N: state=PRESS1 and held=1 after edge N.
- LONG: prss at edge N causes evt_valid=1 after edge N+LONG_TICKS.
- SHORT: rls at edge M causes evt_valid=1 after edge M+GAP_TICKS.
- DOUBLE: second rls at edge K causes evt_valid=1 after edge K+1.
- All outputs are registered. There is no combinational path from prss/rls/evt_ready to any output.

## Structure
- Shared package pb_pkg: evt code localparams (EVT_NONE, EVT_SHORT, EVT_LONG, EVT_DOUBLE) and the state encoding. The debounce stage and the serial command logic also use this package.
- One sub-module, pb_evt_slot: a one-entry valid/ready holding register with overflow pulse. The FSM and counter stay in pb_gesture.

## Test plan
All scenarios use LONG_TICKS=8, GAP_TICKS=5.
- prss, rls 3 cycles later, then idle -> exactly one SHORT (01), 5 cycles after rls. held high for the 3 cycles.
- prss, no rls for 20 cycles -> LONG (10), 8 cycles after prss. Later rls produces no event and held falls.
- prss, rls +2, prss +2, rls +2 -> one DOUBLE (11), 1 cycle after the second rls. No SHORT is emitted.
- rls exactly on the terminal-count cycle of PRESS1 -> classified SHORT, not LONG. prss on the GAP timeout cycle -> DOUBLE path taken.
- evt_ready held low, two complete gestures -> first event held stable, second dropped with a one-cycle evt_ovf. evt_ready pulse then clears evt_valid.
- rst asserted during PRESS1 with an event pending -> all outputs return to reset values immediately. The next prss starts a fresh gesture.
